// File: rtl/wb_stream_writer.sv
// wb_stream_writer: Wishbone classic-cycle write master that copies a
// valid/ready word stream into consecutive slave words starting at a
// command-supplied byte address. Optional ack timeout is compiled in with
// the macro WB_STREAM_WRITER_TIMEOUT_EN.
module wb_stream_writer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH    = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_we_o,
    output logic [SELECT_WIDTH-1:0] wb_sel_o,
    output logic                    wb_stb_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output logic                    wb_cyc_o,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_WRITE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(SELECT_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(SELECT_WIDTH);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    tmo_hit;

`ifdef WB_STREAM_WRITER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // abort on the edge that completes TIMEOUT strobe cycles without a response
    assign tmo_hit = (state_q == ST_WRITE) && (tmo_q == TMO_W'(TIMEOUT - 1));

    // count strobe cycles in WRITE; restarts from zero on every strobe start
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_WRITE) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // timeout counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // next-state and datapath decode; every output below comes from a flop
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        len_d   = len_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        done_d  = 1'b0;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    adr_d   = cmd_addr & ALIGN_MASK;
                    len_d   = cmd_len;
                    error_d = 1'b0;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (s_tvalid) begin
                    dat_d   = s_tdata;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // err wins over a simultaneous ack; a timeout behaves like err
                if (wb_err_i || tmo_hit) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (wb_ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    adr_d = adr_q + ADDR_STEP;
                    len_d = len_q - LEN_WIDTH'(1);
                    if (len_q == LEN_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    // state and output registers; reset abandons any in-flight write silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            len_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            len_q   <= len_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign s_tready  = (state_q == ST_WAIT_DATA);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = cyc_q;
    assign wb_sel_o  = {SELECT_WIDTH{cyc_q}};

endmodule

// File: tb/tb_wb_stream_writer.sv
// Testbench for wb_stream_writer: stream source, Wishbone slave with
// configurable ack latency / error injection, and a reference model that
// predicts the written words, their addresses, error and done timing.
`timescale 1ns/1ps
module tb_wb_stream_writer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int LW = 16;
`ifdef WB_STREAM_WRITER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif
    localparam int NEVER = 1000000;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic          wb_we_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_stb_o;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          wb_cyc_o;
    logic          busy;
    logic          done;
    logic          error;

    wb_stream_writer #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SELECT_WIDTH(SW),
        .LEN_WIDTH   (LW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_we_o  (wb_we_o),
        .wb_sel_o (wb_sel_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_cyc_o (wb_cyc_o),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // shared environment state
    int            cyc_cnt = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            stb_rise_cyc = 0;
    int            cyc_rises = 0;
    int            tready_seen = 0;
    logic          prev_cyc = 1'b0;
    int            ack_wait = 1;
    int            err_at = -1;
    int            wr_idx = 0;
    int            gap_mode = 0;
    logic [3:0]    gap_pat = 4'b1001;
    int            gap_ph = 0;
    logic          hs = 1'b0;
    int            waited = 0;
    logic [AW-1:0] cap_a;
    logic [DW-1:0] cap_d;
    logic [DW-1:0] str_q[$];
    logic [AW-1:0] got_adr[$];
    logic [DW-1:0] got_dat[$];

    // cycle counter, done/busy relation and bus control signal monitor
    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt++;
            #1;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc_cnt;
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy_with_done: busy=%b required 0", busy);
                end
            end
            if (wb_cyc_o === 1'b1 && prev_cyc !== 1'b1) begin
                cyc_rises++;
                stb_rise_cyc = cyc_cnt;
            end
            prev_cyc = wb_cyc_o;
            if (s_tready === 1'b1) tready_seen++;
            vectors++;
            if (wb_sel_o !== {SW{wb_cyc_o}} || wb_we_o !== wb_cyc_o || wb_stb_o !== wb_cyc_o) begin
                miscompares++;
                $display("FAIL bus_ctl: cyc=%b stb=%b we=%b sel=%h", wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o);
            end
        end
    end

    // Wishbone slave: response after ack_wait strobe cycles, one-cycle ack/err
    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (wb_ack_i || wb_err_i) begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                waited = 0;
                vectors++;
                if (wb_stb_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stb_after_ack: stb=%b required 0", wb_stb_o);
                end
            end else if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1) begin
                if (waited == 0) begin
                    cap_a = wb_adr_o;
                    cap_d = wb_dat_o;
                end else begin
                    vectors++;
                    if (wb_adr_o !== cap_a || wb_dat_o !== cap_d) begin
                        miscompares++;
                        $display("FAIL hold_stable: adr=%h dat=%h required adr=%h dat=%h",
                                 wb_adr_o, wb_dat_o, cap_a, cap_d);
                    end
                end
                if (waited >= ack_wait) begin
                    if (wr_idx == err_at) begin
                        wb_err_i = 1'b1;
                    end else begin
                        wb_ack_i = 1'b1;
                        got_adr.push_back(wb_adr_o);
                        got_dat.push_back(wb_dat_o);
                    end
                    wr_idx++;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    // stream source: presents str_q in order; gap_mode 0 none, 1 pattern 1001, 2 random
    initial begin
        s_tvalid = 1'b0;
        s_tdata  = '0;
        forever begin
            @(negedge clk);
            hs = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            if (hs && str_q.size() > 0) void'(str_q.pop_front());
            gap_ph = (gap_ph + 1) % 4;
            if (str_q.size() > 0 &&
                (gap_mode == 0 || (gap_mode == 1 && gap_pat[gap_ph] == 1'b1) ||
                 (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
                s_tvalid = 1'b1;
                s_tdata  = str_q[0];
            end else begin
                s_tvalid = 1'b0;
                s_tdata  = '0;
            end
        end
    end

    // issue one command, wait for completion and compare against the model
    task automatic run_cmd(input string name, input logic [AW-1:0] addr, input int len,
                           input int aw, input int ea, input int gm, input logic [DW-1:0] dbase);
        logic [DW-1:0] words[$];
        logic [AW-1:0] base;
        logic [AW-1:0] exp_a;
        int n;
        int t0;
        bit timed_out;
        bit exp_err;
        words = {};
        for (int i = 0; i < len; i++) begin
            if (dbase != '0) words.push_back(dbase + DW'(i));
            else words.push_back($urandom);
        end
        ack_wait = aw;
        err_at = ea;
        gap_mode = gm;
        wr_idx = 0;
        got_adr = {};
        got_dat = {};
        done_cnt = 0;
        cyc_rises = 0;
        tready_seen = 0;
        str_q = words;
        cmd_addr = addr;
        cmd_len = len[LW-1:0];
        cmd_valid = 1'b1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s cmd_ready: got %b required 1", name, cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        t0 = cyc_cnt;
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL %s error_clear: got %b required 0", name, error);
        end
        timed_out = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        vectors++;
        if (timed_out) begin
            miscompares++;
            $display("FAIL %s done_wait: no done within 4000 cycles", name);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt);
        end
        exp_err = (ea >= 0 && ea < len);
        n = exp_err ? ea : len;
        base = (addr / SW) * SW;
        vectors++;
        if (got_adr.size() != n) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d required %0d", name, got_adr.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_a = base + AW'(SW * i);
                vectors++;
                if (got_adr[i] !== exp_a || got_dat[i] !== words[i]) begin
                    miscompares++;
                    $display("FAIL %s write[%0d]: got %h@%h required %h@%h",
                             name, i, got_dat[i], got_adr[i], words[i], exp_a);
                end
            end
        end
        vectors++;
        if (error !== exp_err) begin
            miscompares++;
            $display("FAIL %s error: got %b required %b", name, error, exp_err);
        end
        if (gm == 0 && aw == 1 && !exp_err) begin
            vectors++;
            if (done_cyc - t0 != 3 * len) begin
                miscompares++;
                $display("FAIL %s latency: got %0d cycles required %0d", name, done_cyc - t0, 3 * len);
            end
        end
        if (len == 0) begin
            vectors++;
            if (cyc_rises != 0 || tready_seen != 0) begin
                miscompares++;
                $display("FAIL %s len0_idle: cyc_rises=%0d tready_cycles=%0d required 0/0",
                         name, cyc_rises, tready_seen);
            end
        end
        str_q = {};
        ack_wait = 1;
        err_at = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0 || wb_sel_o !== '0 ||
            wb_adr_o !== '0 || wb_dat_o !== '0) begin
            miscompares++;
            $display("FAIL reset_bus: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h required all 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || cmd_ready !== 1'b1 || s_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: busy=%b done=%b error=%b cmd_ready=%b s_tready=%b required 0 0 0 1 0",
                     busy, done, error, cmd_ready, s_tready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_cmd("basic", 32'h0000_0100, 4, 1, -1, 0, 32'h0000_00A0);
    endtask

    task automatic test_len_zero();
        run_cmd("len_zero", 32'h0000_0200, 0, 1, -1, 0, '0);
    endtask

    task automatic test_wrap();
        run_cmd("wrap", 32'hFFFF_FFFC, 2, 1, -1, 0, '0);
    endtask

    task automatic test_gaps_slow();
        run_cmd("gaps_slow", 32'h0000_0403, 3, 5, -1, 1, '0);
    endtask

    task automatic test_error();
        run_cmd("error", 32'h0000_0800, 4, 1, 1, 0, '0);
        run_cmd("after_error", 32'h0000_0900, 2, 1, -1, 0, '0);
    endtask

    task automatic test_rst_mid_write();
        bit seen;
        ack_wait = NEVER;
        err_at = -1;
        gap_mode = 0;
        done_cnt = 0;
        str_q = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        cmd_addr = 32'h0000_0C00;
        cmd_len = 16'd3;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (wb_stb_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL rst_mid stb_wait: stb never rose");
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid state: cyc=%b stb=%b busy=%b cmd_ready=%b required 0 0 0 1",
                     wb_cyc_o, wb_stb_o, busy, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        str_q = {};
        ack_wait = 1;
        repeat (3) @(negedge clk);
        vectors++;
        if (done_cnt != 0) begin
            miscompares++;
            $display("FAIL rst_mid done: got %0d pulses required 0", done_cnt);
        end
        run_cmd("after_rst", 32'h0000_0D00, 3, 1, -1, 0, '0);
    endtask

`ifdef WB_STREAM_WRITER_TIMEOUT_EN
    task automatic test_timeout();
        bit timed_out;
        ack_wait = NEVER;
        err_at = -1;
        gap_mode = 0;
        done_cnt = 0;
        got_adr = {};
        got_dat = {};
        str_q = {32'hDEAD_0001, 32'hDEAD_0002};
        cmd_addr = 32'h0000_0E00;
        cmd_len = 16'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        vectors++;
        if (timed_out) begin
            miscompares++;
            $display("FAIL timeout done_wait: no abort within 200 cycles");
        end
        vectors++;
        if (done_cyc - stb_rise_cyc != TMO) begin
            miscompares++;
            $display("FAIL timeout delay: got %0d cycles required %0d", done_cyc - stb_rise_cyc, TMO);
        end
        vectors++;
        if (error !== 1'b1 || wb_cyc_o !== 1'b0 || got_adr.size() != 0) begin
            miscompares++;
            $display("FAIL timeout status: error=%b cyc=%b writes=%0d required 1 0 0",
                     error, wb_cyc_o, got_adr.size());
        end
        str_q = {};
        ack_wait = 1;
        repeat (3) @(negedge clk);
    endtask
`endif

    task automatic test_random();
        int len;
        int ea;
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, 6);
            ea = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            run_cmd("random", $urandom, len, $urandom_range(0, 3), ea, 2, '0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_gaps_slow();
        test_error();
        test_rst_mid_write();
`ifdef WB_STREAM_WRITER_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
